roi_band_detect: RTL and testbench

Parametrised successor to the in-line ROI row-run tracker on the binary camera path. It sits after RAW2BW on the CCD_PIXCLK domain and watches the 1-bit pixel stream for a horizontal band whose longest white run drops below, then rises back above, a ratio of the previous row's run. It reports the band's row span and white-pixel column extent per frame, and drives a record strobe for the ROI capture block. Thresholds, gap length, widths and arm mode are parameters.

---
 rtl/roi_pkg.sv | 15 +
 rtl/roi_band_detect_if.sv | 15 +
 rtl/roi_row_stats.sv | 54 +++++
 rtl/roi_band_detect.sv | 97 +++++++++
 tb/tb_roi_band_detect.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/roi_pkg.sv
// roi_pkg: shared state encoding, default ratios and threshold helper for roi_band_detect.
package roi_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FRAME = 3'd1,
      BEFORE     = 3'd2,
      INSIDE     = 3'd3,
      AFTER      = 3'd4
   } state_t;
   localparam int ENTER_Q_DEF = 3;
   localparam int EXIT_Q_DEF  = 6;
   function automatic logic [31:0] scale_q(input logic [31:0] prev, input logic [31:0] q);
      return (prev * q) >> 2;
   endfunction
endpackage

// File: rtl/roi_band_detect_if.sv
// roi_band_detect_if: binary pixel stream in, band result and record strobe out.
interface roi_band_detect_if #(
   parameter int X_W = 12,
   parameter int Y_W = 12
);
   logic           iDATA, iDVAL, iFVAL, iARM;
   logic           oRECORD, oDONE;
   logic [Y_W-1:0] oROW_START, oROW_END;
   logic [X_W-1:0] oCOL_MIN, oCOL_MAX;
   logic [2:0]     oSTATE;
   modport master (output iDATA, iDVAL, iFVAL, iARM,
                   input oRECORD, oDONE, oROW_START, oROW_END, oCOL_MIN, oCOL_MAX, oSTATE);
   modport slave (input iDATA, iDVAL, iFVAL, iARM,
                  output oRECORD, oDONE, oROW_START, oROW_END, oCOL_MIN, oCOL_MAX, oSTATE);
endinterface

// File: rtl/roi_row_stats.sv
// roi_row_stats: per-row longest white run, column index and line-gap boundary detection.
module roi_row_stats #(
   parameter int X_W      = 12,
   parameter int RUN_W    = 10,
   parameter int LINE_GAP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             flush_i,
   input  logic             data_i,
   input  logic             dval_i,
   output logic             row_done_o,
   output logic [RUN_W-1:0] row_max_o,
   output logic [X_W-1:0]   col_idx_o
);
   localparam int GW = $clog2(LINE_GAP + 2);
   logic [GW-1:0]    gap_q, gap_d;
   logic             seen_q, seen_d;
   logic [RUN_W-1:0] run_q, run_d, max_q, max_d, run_inc;
   logic [X_W-1:0]   col_q, col_d;
   // a valid pixel on the completing cycle keeps the row open
   always_comb begin
      run_inc = &run_q ? run_q : run_q + 1'b1;
      row_done_o = seen_q && !dval_i && (flush_i || gap_q == GW'(LINE_GAP));
      gap_d = dval_i ? '0 : (gap_q == GW'(LINE_GAP + 1) ? gap_q : gap_q + 1'b1);
      seen_d = dval_i || (seen_q && !row_done_o);
      run_d = row_done_o ? '0 : !dval_i ? run_q : data_i ? run_inc : '0;
      max_d = row_done_o ? '0 : (dval_i && data_i && run_inc > max_q) ? run_inc : max_q;
      col_d = row_done_o ? '0 : dval_i ? col_q + 1'b1 : col_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gap_q  <= '0;
         seen_q <= 1'b0;
         run_q  <= '0;
         max_q  <= '0;
         col_q  <= '0;
      end else if (clr_i) begin
         gap_q  <= '0;
         seen_q <= 1'b0;
         run_q  <= '0;
         max_q  <= '0;
         col_q  <= '0;
      end else begin
         gap_q  <= gap_d;
         seen_q <= seen_d;
         run_q  <= run_d;
         max_q  <= max_d;
         col_q  <= col_d;
      end
   assign row_max_o = max_q;
   assign col_idx_o = col_q;
endmodule

// File: rtl/roi_band_detect.sv
// roi_band_detect: finds a band of rows whose longest white run dips below, then recovers above,
// a ratio of the previous row's run; reports row span and white column extent once per frame.
module roi_band_detect import roi_pkg::*; #(
   parameter int X_W      = 12,
   parameter int Y_W      = 12,
   parameter int RUN_W    = 10,
   parameter int LINE_GAP = 4,
   parameter int ENTER_Q  = ENTER_Q_DEF,
   parameter int EXIT_Q   = EXIT_Q_DEF,
   parameter int REARM    = 0
) (
   input logic               iCLK,
   input logic               iRST,
   roi_band_detect_if.slave  bus
);
   localparam int TW = RUN_W + 3;
   state_t           state_q, state_d, mid;
   logic             fval_q, rec_q, done_q;
   logic             active, start, fend, enter, leave, pix, load, row_done;
   logic [Y_W-1:0]   row_q, start_q, start_d, end_q, end_d, ostart_q, oend_q;
   logic [X_W-1:0]   cmin_q, cmin_d, cmax_q, cmax_d, ocmin_q, ocmax_q, col_idx;
   logic [RUN_W-1:0] prev_q, row_max;
   logic [TW-1:0]    enter_thr, exit_thr;
   roi_row_stats #(.X_W(X_W), .RUN_W(RUN_W), .LINE_GAP(LINE_GAP)) u_stats (
      .clk(iCLK), .rst(iRST), .clr_i(!active && !start), .flush_i(fend),
      .data_i(bus.iDATA), .dval_i(bus.iDVAL),
      .row_done_o(row_done), .row_max_o(row_max), .col_idx_o(col_idx)
   );
   assign enter_thr = TW'(scale_q(32'(prev_q), 32'(ENTER_Q)));
   assign exit_thr  = TW'(scale_q(32'(prev_q), 32'(EXIT_Q)));
   // mid is the state after evaluating this cycle's row, before frame-end handling
   always_comb begin
      active = state_q inside {BEFORE, INSIDE, AFTER};
      start = state_q == WAIT_FRAME && bus.iFVAL && !fval_q;
      fend = active && !bus.iFVAL && fval_q;
      enter = row_done && state_q == BEFORE && row_q != '0 && {3'b0, row_max} < enter_thr;
      leave = row_done && state_q == INSIDE && {3'b0, row_max} > exit_thr;
      mid = enter ? INSIDE : leave ? AFTER : state_q;
      pix = state_q == INSIDE && bus.iDVAL && bus.iDATA;
      start_d = enter ? row_q : start_q;
      end_d = leave ? row_q - 1'b1 : (fend && mid == INSIDE) ? (row_done ? row_q : row_q - 1'b1) : end_q;
      cmin_d = enter ? '1 : (pix && col_idx < cmin_q) ? col_idx : cmin_q;
      cmax_d = enter ? '0 : (pix && col_idx > cmax_q) ? col_idx : cmax_q;
      load = fend && mid != BEFORE;
      state_d = fend ? ((REARM != 0 || bus.iARM) ? WAIT_FRAME : IDLE)
              : active ? mid
              : state_q == IDLE ? (bus.iARM ? WAIT_FRAME : IDLE)
              : state_q == WAIT_FRAME ? (start ? BEFORE : WAIT_FRAME) : IDLE;
   end
   // fval_q resets high so a frame already in progress at release is not mistaken for a new one
   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         state_q  <= IDLE;
         fval_q   <= 1'b1;
         rec_q    <= 1'b0;
         done_q   <= 1'b0;
         row_q    <= '0;
         prev_q   <= '0;
         start_q  <= '0;
         end_q    <= '0;
         cmin_q   <= '0;
         cmax_q   <= '0;
         ostart_q <= '0;
         oend_q   <= '0;
         ocmin_q  <= '0;
         ocmax_q  <= '0;
      end else begin
         state_q <= state_d;
         fval_q  <= bus.iFVAL;
         rec_q   <= !fend && (enter || (rec_q && !leave));
         done_q  <= load;
         start_q <= start_d;
         end_q   <= end_d;
         cmin_q  <= cmin_d;
         cmax_q  <= cmax_d;
         if (!active) begin
            row_q  <= '0;
            prev_q <= '0;
         end else if (row_done) begin
            row_q  <= row_q + 1'b1;
            prev_q <= row_max;
         end
         if (load) begin
            ostart_q <= start_d;
            oend_q   <= end_d;
            ocmin_q  <= cmin_d;
            ocmax_q  <= cmax_d;
         end
      end
   assign bus.oRECORD    = rec_q;
   assign bus.oDONE      = done_q;
   assign bus.oROW_START = ostart_q;
   assign bus.oROW_END   = oend_q;
   assign bus.oCOL_MIN   = ocmin_q;
   assign bus.oCOL_MAX   = ocmax_q;
   assign bus.oSTATE     = state_q;
endmodule

// File: tb/tb_roi_band_detect.sv
// tb_roi_band_detect: directed frames against a one-shot and a re-arming instance.
module tb_roi_band_detect;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int n0 = 0;
   int n1 = 0;
   roi_band_detect_if b0 ();
   roi_band_detect_if b1 ();
   assign b1.iDATA = b0.iDATA;
   assign b1.iDVAL = b0.iDVAL;
   assign b1.iFVAL = b0.iFVAL;
   assign b1.iARM  = b0.iARM;
   roi_band_detect #(.REARM(0)) dut0 (.iCLK(clk), .iRST(rst), .bus(b0));
   roi_band_detect #(.REARM(1)) dut1 (.iCLK(clk), .iRST(rst), .bus(b1));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (b0.oDONE) n0++;
      if (b1.oDONE) n1++;
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   // one row: white run a..a+n-1 plus lone whites at lo/hi, w pixels, then gap idle cycles
   task automatic row(input int a, input int n, input int lo, input int hi, input int w, input int gap);
      for (int c = 0; c < w; c++) begin
         b0.iDVAL = 1'b1;
         b0.iDATA = (c >= a && c < a + n) || c == lo || c == hi;
         tick();
      end
      b0.iDVAL = 1'b0;
      b0.iDATA = 1'b0;
      repeat (gap) tick();
   endtask
   initial begin
      b0.iDATA = 1'b0;
      b0.iDVAL = 1'b0;
      b0.iFVAL = 1'b0;
      b0.iARM  = 1'b0;
      tick();
      tick();
      chk("rst_state", b0.oSTATE, 0);
      chk("rst_record", b0.oRECORD, 0);
      chk("rst_done", b0.oDONE, 0);
      chk("rst_row_start", b0.oROW_START, 0);
      chk("rst_col_min", b0.oCOL_MIN, 0);
      rst = 1'b0;
      tick();
      b0.iARM = 1'b1;
      tick();
      chk("arm_wait", b0.oSTATE, 1);
      b0.iARM = 1'b0;
      // frame A: band rows 10..14
      b0.iFVAL = 1'b1;
      tick();
      tick();
      for (int r = 0; r < 10; r++) row(50, 40, 0, 200, 210, 6);
      row(40, 20, -1, -1, 210, 6);
      chk("a_rec_enter", b0.oRECORD, 1);
      row(33, 20, 87, -1, 210, 6);
      chk("a_rec_in", b0.oRECORD, 1);
      chk("a_state_in", b0.oSTATE, 3);
      repeat (3) row(50, 20, -1, -1, 210, 6);
      row(45, 40, -1, -1, 210, 6);
      chk("a_rec_exit", b0.oRECORD, 0);
      chk("a_state_after", b0.oSTATE, 4);
      repeat (4) row(50, 40, 0, 200, 210, 6);
      b0.iFVAL = 1'b0;
      tick();
      chk("a_done0", b0.oDONE, 1);
      chk("a_done1", b1.oDONE, 1);
      chk("a_row_start", b0.oROW_START, 10);
      chk("a_row_end", b0.oROW_END, 14);
      chk("a_col_min", b0.oCOL_MIN, 33);
      chk("a_col_max", b0.oCOL_MAX, 87);
      chk("a_idle0", b0.oSTATE, 0);
      chk("a_rearm1", b1.oSTATE, 1);
      tick();
      chk("a_done_pulse", b0.oDONE, 0);
      // frame B: band open at frame end, last row without trailing gap
      repeat (3) tick();
      b0.iFVAL = 1'b1;
      tick();
      tick();
      for (int r = 0; r < 100; r++) row(5, 40, -1, -1, 50, 6);
      row(5, 20, -1, -1, 50, 6);
      chk("b_rec_enter", b1.oRECORD, 1);
      for (int r = 101; r < 479; r++) row(5, 20, -1, -1, 50, 6);
      row(5, 20, -1, -1, 50, 0);
      b0.iFVAL = 1'b0;
      tick();
      chk("b_done1", b1.oDONE, 1);
      chk("b_row_start", b1.oROW_START, 100);
      chk("b_row_end", b1.oROW_END, 479);
      chk("b_col_min", b1.oCOL_MIN, 5);
      chk("b_col_max", b1.oCOL_MAX, 24);
      chk("b_done0_none", b0.oDONE, 0);
      chk("b_idle0", b0.oSTATE, 0);
      chk("b_hold0", b0.oROW_START, 10);
      tick();
      chk("b_count0", n0, 1);
      chk("b_count1", n1, 2);
      // frame C: gap of 4 is not a boundary, gap of 5 is; then reset inside the band
      repeat (3) tick();
      b0.iFVAL = 1'b1;
      tick();
      tick();
      repeat (5) row(5, 40, -1, -1, 50, 6);
      row(0, 10, -1, -1, 10, 4);
      row(0, 40, -1, -1, 50, 6);
      chk("c_gap4_rec", b1.oRECORD, 0);
      chk("c_gap4_state", b1.oSTATE, 2);
      row(0, 10, -1, -1, 10, 4);
      chk("c_gap5_early", b1.oRECORD, 0);
      tick();
      chk("c_gap5_rec", b1.oRECORD, 1);
      chk("c_gap5_state", b1.oSTATE, 3);
      rst = 1'b1;
      #1;
      chk("c_rst_rec", b1.oRECORD, 0);
      chk("c_rst_state", b1.oSTATE, 0);
      chk("c_rst_start", b1.oROW_START, 0);
      chk("c_rst_end", b1.oROW_END, 0);
      chk("c_rst_cmax", b1.oCOL_MAX, 0);
      tick();
      rst = 1'b0;
      tick();
      b0.iARM = 1'b1;
      row(5, 20, -1, -1, 50, 6);
      chk("c_no_midframe1", b1.oSTATE, 1);
      chk("c_no_midframe0", b0.oSTATE, 1);
      b0.iFVAL = 1'b0;
      repeat (3) tick();
      // frame D: saturating run, band at row 2 only
      b0.iFVAL = 1'b1;
      tick();
      tick();
      row(0, 1100, -1, -1, 1100, 0);
      chk("d_sat_max", dut1.u_stats.row_max_o, 1023);
      repeat (6) tick();
      row(10, 900, -1, -1, 950, 6);
      chk("d_no_enter", b1.oRECORD, 0);
      row(10, 40, -1, -1, 60, 6);
      chk("d_rec_enter", b1.oRECORD, 1);
      row(10, 80, -1, -1, 100, 6);
      chk("d_rec_exit", b1.oRECORD, 0);
      row(0, 40, -1, -1, 50, 6);
      b0.iFVAL = 1'b0;
      tick();
      chk("d_done0", b0.oDONE, 1);
      chk("d_done1", b1.oDONE, 1);
      chk("d_row_start", b1.oROW_START, 2);
      chk("d_row_end", b1.oROW_END, 2);
      chk("d_col_min", b1.oCOL_MIN, 10);
      chk("d_col_max", b1.oCOL_MAX, 89);
      chk("d_row_start0", b0.oROW_START, 2);
      chk("d_col_max0", b0.oCOL_MAX, 89);
      tick();
      b0.iARM = 1'b0;
      tick();
      chk("d_count0", n0, 2);
      chk("d_count1", n1, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
